// File: rtl/mem_cycle_ctrl_pkg.sv
// Shared definitions for the bus-cycle controller: FSM state codes and latched device codes.
package mem_cycle_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_ERR    = 3'd4;

    localparam logic [1:0] DEV_NONE = 2'd0;
    localparam logic [1:0] DEV_CS2  = 2'd1;
    localparam logic [1:0] DEV_CS4  = 2'd2;
    localparam logic [1:0] DEV_CS6  = 2'd3;

endpackage

// File: rtl/mem_cycle_ctrl_if.sv
// CPU/decoder-facing bus of the cycle controller; master drives requests, slave returns strobes and status.
interface mem_cycle_ctrl_if;

    logic       AS;
    logic       RW;
    logic       CS2_N;
    logic       CS4_N;
    logic       CS6_N;
    logic       OE_N;
    logic       WE_N;
    logic [1:0] DEV;
    logic       BUSY;
    logic       READY;
    logic       BUS_ERR;

    modport master (
        output AS, RW, CS2_N, CS4_N, CS6_N,
        input  OE_N, WE_N, DEV, BUSY, READY, BUS_ERR
    );

    modport slave (
        input  AS, RW, CS2_N, CS4_N, CS6_N,
        output OE_N, WE_N, DEV, BUSY, READY, BUS_ERR
    );

endinterface

// File: rtl/mem_cycle_ctrl_ws_counter.sv
// Loadable wait-state down-counter; load wins over decrement and the count never wraps below zero.
module ws_counter #(
    parameter int unsigned WAIT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Bus-cycle controller: turns an accepted address strobe into SETUP/STROBE/HOLD timing with
// per-device wait states, a one-cycle READY, and BUS_ERR when no chip select was active.
module mem_cycle_ctrl
    import mem_cycle_ctrl_pkg::*;
#(
    parameter int unsigned       WAIT_W = 4,
    parameter logic [WAIT_W-1:0] WAIT2  = 4'd0,
    parameter logic [WAIT_W-1:0] WAIT4  = 4'd2,
    parameter logic [WAIT_W-1:0] WAIT6  = 4'd5
) (
    input  logic             CLK,
    input  logic             RST,
    mem_cycle_ctrl_if.slave  bus
);

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [1:0]        dev_q, dev_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic [1:0]        sel_dev;
    logic [WAIT_W-1:0] sel_wait;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    // Several selects can be low together; the lowest-numbered device wins.
    always_comb begin
        sel_dev  = DEV_NONE;
        sel_wait = '0;
        if (!bus.CS2_N) begin
            sel_dev  = DEV_CS2;
            sel_wait = WAIT2;
        end else if (!bus.CS4_N) begin
            sel_dev  = DEV_CS4;
            sel_wait = WAIT4;
        end else if (!bus.CS6_N) begin
            sel_dev  = DEV_CS6;
            sel_wait = WAIT6;
        end
    end

    ws_counter #(
        .WAIT_W (WAIT_W)
    ) u_ws_counter (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (sel_wait),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        dev_d    = dev_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.AS) begin
                    rw_d     = bus.RW;
                    dev_d    = sel_dev;
                    cnt_load = 1'b1;
                    state_d  = (sel_dev == DEV_NONE) ? ST_ERR : ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it (Moore, no input-to-output path).
    always_comb begin
        oe_n_d  = !((state_d == ST_STROBE) && rw_d);
        we_n_d  = !((state_d == ST_STROBE) && !rw_d);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_HOLD) || (state_d == ST_ERR);
        err_d   = (state_d == ST_ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            dev_q   <= DEV_NONE;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign bus.OE_N    = oe_n_q;
    assign bus.WE_N    = we_n_q;
    assign bus.DEV     = dev_q;
    assign bus.BUSY    = busy_q;
    assign bus.READY   = ready_q;
    assign bus.BUS_ERR = err_q;

endmodule

// File: doc/mem_cycle_ctrl.md
# mem_cycle_ctrl

Bus-cycle controller that sits directly downstream of the address chip-select decoder. It consumes the decoder's active-low selects CS2/CS4/CS6 plus a CPU address strobe. For each access it generates timed active-low output-enable and write-enable strobes, with a per-device wait-state count. It returns a one-cycle READY to the CPU, and flags BUS_ERR when no device is selected.

## Interface
- WAIT_W, 4, width of wait-state counter and wait parameters
- WAIT2, 4'd0, extra STROBE cycles for the CS2 device
- WAIT4, 4'd2, extra STROBE cycles for the CS4 device
- WAIT6, 4'd5, extra STROBE cycles for the CS6 device

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- AS  in  1  address strobe, high for one cycle to request an access
- RW  in  1  1 = read, 0 = write; sampled with AS
- CS2_N  in  1  active-low select from decoder
- CS4_N  in  1  active-low select from decoder
- CS6_N  in  1  active-low select from decoder
- OE_N  out  1  active-low output enable (reads)
- WE_N  out  1  active-low write enable (writes)
- DEV  out  2  latched device code: 0 none, 1 CS2, 2 CS4, 3 CS6
- BUSY  out  1  high while a cycle is in progress
- READY  out  1  one-cycle completion pulse
- BUS_ERR  out  1  one-cycle pulse, concurrent with READY, when no select was active

## Operation
- Reset values: OE_N=1, WE_N=1, DEV=0, BUSY=0, READY=0, BUS_ERR=0, state IDLE, counter 0.
- States: IDLE, SETUP, STROBE, HOLD, ERR.
- **IDLE**
  - On AS=1, latch RW and the device, then take the first matching branch:
    - CS2_N=0 -> DEV=1, counter=WAIT2, go to SETUP.
    - CS4_N=0 -> DEV=2, counter=WAIT4, go to SETUP.
    - CS6_N=0 -> DEV=3, counter=WAIT6, go to SETUP.
    - All selects high -> DEV=0, go to ERR.
  - Selects are priority-resolved, CS2 > CS4 > CS6, because several selects may be low at once.
- **SETUP**
  - One cycle; strobes high (address setup).
  - Go to STROBE.
- **STROBE**
  - OE_N=0 if latched RW=1, else WE_N=0.
  - If counter=0, go to HOLD; else decrement the counter and stay.
- **HOLD**
  - Strobes high; READY=1.
  - Go to IDLE.
- **ERR**
  - READY=1, BUS_ERR=1, strobes never asserted.
  - Go to IDLE.
- BUSY=1 in every state except IDLE.
- DEV holds its value until the next accepted AS.
- AS while BUSY=1 is ignored; requests are not queued. The CPU must wait for READY.
- Selects and RW are sampled only on the accepted AS edge; later changes have no effect on the current cycle.
- Asynchronous RST mid-cycle immediately forces strobes high, READY/BUS_ERR low, state IDLE. No READY is issued for the aborted cycle.

## Timing
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- For AS sampled at edge 0 with wait count W:
  - SETUP occupies cycle 1.
  - STROBE occupies cycles 2..2+W (W+1 cycles).
  - HOLD/READY occurs in cycle 3+W.
  - Total latency from AS to READY: W+3 cycles.
- Error cycle: READY and BUS_ERR high in cycle 1.
- Back-to-back: AS may be asserted in the same cycle READY is high. Because the state is HOLD, not IDLE, that AS is ignored. The earliest accepted AS is the cycle after READY.
- OE_N and WE_N are never low simultaneously. Neither is low in SETUP, HOLD, ERR, or IDLE.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, SETUP, STROBE, HOLD, ERR);
  - DEV code constants (DEV_NONE=0, DEV_CS2=1, DEV_CS4=2, DEV_CS6=3).
- One natural sub-module: ws_counter.
  - Loadable WAIT_W-bit down-counter with load, decrement, and zero flag.
  - Instantiated once.
- Select priority resolution and wait-value mux stay in the top-level module.

## Test plan
- Reset: assert RST mid-run -> all outputs at reset values immediately, without waiting for CLK; BUSY=0.
- Read to CS2 (WAIT2=0): AS=1, RW=1, CS2_N=0 -> OE_N low for exactly 1 cycle (cycle 2), READY in cycle 3, DEV=1, WE_N stays 1.
- Write to CS6 (WAIT6=5): AS=1, RW=0, CS6_N=0 -> WE_N low for exactly 6 cycles (cycles 2–7), READY in cycle 8, DEV=3.
- Priority and error:
  - CS2_N=0 and CS6_N=0 together -> DEV=1 and 1-cycle strobe.
  - All selects high -> READY and BUS_ERR in cycle 1, no strobe.
- Ignored requests:
  - AS re-pulsed during STROBE and in the READY cycle of a CS4 read -> no extra cycle, DEV unchanged.
  - AS one cycle after READY is accepted.
- Reset mid-STROBE of a CS6 write: RST pulse while WE_N=0 -> WE_N=1 immediately, no READY. A subsequent CS4 read then completes normally in 5 cycles.
